cfi_log_serializer: RTL and testbench

CFI_LOG_SERIALIZER -- requirements
Module: cfi_log_serializer

---
 rtl/cfi_log_serializer.sv | 173 +++++++++++++++++
 tb/tb_cfi_log_serializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cfi_log_serializer.sv
// ----------------------------------------------------------------------------
// cfi_log_serializer
//
// Purpose:
//   Collects commit-log entries of control-flow instructions from several
//   commit ports. It packs them into a small circular staging buffer and
//   presents them one at a time to a downstream CFI log queue using a
//   valid/ready handshake.
//   Once the buffer can no longer absorb a full cycle of commits, commit is
//   stalled through cfi_halt_o.
//
// Ports:
//   clk_i          single clock, all state changes on its rising edge
//   rst_i          synchronous active-high reset
//   flush_i        discards every buffered entry
//   log_i          commit log per port, port k at [k*LOG_WIDTH +: LOG_WIDTH]
//   log_cfi_i      port k carries a control-flow instruction
//   log_ack_i      port k commits this cycle
//   queue_valid_o  head entry valid toward the log queue
//   queue_ready_i  log queue accepts the head entry
//   queue_data_o   head entry payload
//   cfi_halt_o     commit stall request
//   occupancy_o    number of buffered entries
//   pushed_cnt_o   accepted entry count (wraps at 2^32)
//   dropped_cnt_o  dropped entry count (saturates at 16'hFFFF)
//
// Configuration:
//   CFI_SERIALIZER_STATS_EN - when defined, the statistics counters are built.
//   When it is undefined, both counter outputs are tied to zero and no
//   counter state exists.
// ----------------------------------------------------------------------------
module cfi_log_serializer #(
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned LOG_WIDTH       = 64,
   parameter int unsigned BUF_DEPTH       = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 flush_i,
   input  logic [NR_COMMIT_PORTS*LOG_WIDTH-1:0] log_i,
   input  logic [NR_COMMIT_PORTS-1:0]           log_cfi_i,
   input  logic [NR_COMMIT_PORTS-1:0]           log_ack_i,
   output logic                                 queue_valid_o,
   input  logic                                 queue_ready_i,
   output logic [LOG_WIDTH-1:0]                 queue_data_o,
   output logic                                 cfi_halt_o,
   output logic [$clog2(BUF_DEPTH):0]           occupancy_o,
   output logic [31:0]                          pushed_cnt_o,
   output logic [15:0]                          dropped_cnt_o
);

   localparam int unsigned OW = $clog2(BUF_DEPTH) + 1;
   localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [PW-1:0] PTR_MASK   = PW'(BUF_DEPTH - 1);
   localparam logic [OW-1:0] HALT_LEVEL = OW'(BUF_DEPTH - NR_COMMIT_PORTS);

   logic [LOG_WIDTH-1:0]       mem_q [BUF_DEPTH];
   logic [LOG_WIDTH-1:0]       mem_d [BUF_DEPTH];
   logic [PW-1:0]              head_q, head_d;
   logic [PW-1:0]              tail_q, tail_d;
   logic [OW-1:0]              occ_q, occ_d;

   logic [NR_COMMIT_PORTS-1:0] eligible;
   logic                       halt;
   logic                       pop;
   logic [OW-1:0]              accept_n;

   assign eligible = log_cfi_i & log_ack_i;

   // Halt depends only on registered occupancy. Below the threshold, one
   // full cycle of commits from every port is guaranteed to fit.
   assign halt = (occ_q > HALT_LEVEL);
   assign pop  = queue_valid_o & queue_ready_i;

   assign queue_valid_o = (occ_q != '0);
   assign queue_data_o  = mem_q[head_q];
   assign cfi_halt_o    = halt;
   assign occupancy_o   = occ_q;

   // Compacting write: eligible ports fill consecutive slots after the tail
   // in ascending port order. accept_n counts the entries taken this cycle
   // even during a flush, so the statistics still see them. The array write
   // itself is suppressed because the flush discards it anyway.
   always_comb begin
      mem_d    = mem_q;
      accept_n = '0;
      if (!halt) begin
         for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (eligible[k]) begin
               if (!flush_i) begin
                  mem_d[(tail_q + PW'(accept_n)) & PTR_MASK] =
                     log_i[k*LOG_WIDTH +: LOG_WIDTH];
               end
               accept_n = accept_n + OW'(1);
            end
         end
      end
   end

   // Pointer and occupancy update. A flush returns the buffer to its empty
   // origin and ignores this cycle's push and pop.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         head_d = (head_q + PW'(pop)) & PTR_MASK;
         tail_d = (tail_q + PW'(accept_n)) & PTR_MASK;
         occ_d  = occ_q + accept_n - OW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   // Buffer contents are not reset. Occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

`ifdef CFI_SERIALIZER_STATS_EN
   logic [31:0]   pushed_cnt_q, pushed_cnt_d;
   logic [15:0]   dropped_cnt_q, dropped_cnt_d;
   logic [OW-1:0] drop_n;
   logic [16:0]   drop_sum;

   // Entries offered while halted are all dropped. The dropped counter
   // saturates, and the pushed counter wraps.
   always_comb begin
      drop_n = '0;
      if (halt) begin
         for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (eligible[k]) begin
               drop_n = drop_n + OW'(1);
            end
         end
      end
      pushed_cnt_d  = pushed_cnt_q + 32'(accept_n);
      drop_sum      = {1'b0, dropped_cnt_q} + 17'(drop_n);
      dropped_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pushed_cnt_q  <= '0;
         dropped_cnt_q <= '0;
      end else begin
         pushed_cnt_q  <= pushed_cnt_d;
         dropped_cnt_q <= dropped_cnt_d;
      end
   end

   assign pushed_cnt_o  = pushed_cnt_q;
   assign dropped_cnt_o = dropped_cnt_q;
`else
   assign pushed_cnt_o  = '0;
   assign dropped_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cfi_log_serializer.sv
// ----------------------------------------------------------------------------
// tb_cfi_log_serializer
//
// Self-checking bench for cfi_log_serializer with 2 ports, depth 4 and
// 64-bit entries.
// The reference is a plain SystemVerilog queue of expected entries:
//   - the stimulus task appends accepted entries and clears the queue on
//     flush or reset;
//   - the monitor pops the queue on every modelled handshake and compares
//     the DUT outputs against the queue size and front element.
// ----------------------------------------------------------------------------
module tb_cfi_log_serializer;

   localparam int N = 2;
   localparam int D = 4;
   localparam int W = 64;

   logic             clk_i;
   logic             rst_i;
   logic             flush_i;
   logic [N*W-1:0]   log_i;
   logic [N-1:0]     log_cfi_i;
   logic [N-1:0]     log_ack_i;
   logic             queue_valid_o;
   logic             queue_ready_i;
   logic [W-1:0]     queue_data_o;
   logic             cfi_halt_o;
   logic [$clog2(D):0] occupancy_o;
   logic [31:0]      pushed_cnt_o;
   logic [15:0]      dropped_cnt_o;

   cfi_log_serializer #(
      .NR_COMMIT_PORTS (N),
      .LOG_WIDTH       (W),
      .BUF_DEPTH       (D)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .log_i         (log_i),
      .log_cfi_i     (log_cfi_i),
      .log_ack_i     (log_ack_i),
      .queue_valid_o (queue_valid_o),
      .queue_ready_i (queue_ready_i),
      .queue_data_o  (queue_data_o),
      .cfi_halt_o    (cfi_halt_o),
      .occupancy_o   (occupancy_o),
      .pushed_cnt_o  (pushed_cnt_o),
      .dropped_cnt_o (dropped_cnt_o)
   );

   // 10 ns clock
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   logic [W-1:0] sb [$];
   int           checks;
   int           errors;
   longint       exp_pushed;
   longint       exp_dropped;
   bit           mon_en;

   task automatic check_output(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act,
                  exp, $time);
      end
   endtask

   // Monitor: samples on the falling edge, compares against the queue state
   // left by the previous cycle, and pops on a modelled handshake.
   initial begin
      forever begin
         @(negedge clk_i);
         if (mon_en) begin
            int occ;
            occ = sb.size();
            check_output("occupancy", 64'(occupancy_o), 64'(occ));
            check_output("valid", 64'(queue_valid_o), 64'(occ != 0));
            check_output("halt", 64'(cfi_halt_o), 64'(occ > D - N));
`ifdef CFI_SERIALIZER_STATS_EN
            check_output("pushed_cnt", 64'(pushed_cnt_o), 64'(exp_pushed & 64'hFFFF_FFFF));
            check_output("dropped_cnt", 64'(dropped_cnt_o), 64'(exp_dropped));
`else
            check_output("pushed_cnt", 64'(pushed_cnt_o), 64'd0);
            check_output("dropped_cnt", 64'(dropped_cnt_o), 64'd0);
`endif
            if (occ > 0) begin
               check_output("data", queue_data_o, sb[0]);
               if (queue_ready_i) begin
                  void'(sb.pop_front());
               end
            end
         end
      end
   end

   // Drives one cycle of inputs, then applies the cycle's effect to the
   // reference queue after the monitor has sampled.
   task automatic apply_stimulus(input logic [N-1:0] cfi, input logic [N-1:0] ack,
                                 input logic [W-1:0] d0, input logic [W-1:0] d1,
                                 input logic rdy, input logic fl, input logic rst);
      bit halted;
      int acc;
      int drp;
      @(posedge clk_i);
      #1;
      log_cfi_i     = cfi;
      log_ack_i     = ack;
      log_i         = {d1, d0};
      queue_ready_i = rdy;
      flush_i       = fl;
      rst_i         = rst;
      halted        = (sb.size() > D - N);
      @(negedge clk_i);
      #1;
      acc = 0;
      drp = 0;
      if (cfi[0] && ack[0]) begin
         if (halted) drp++; else begin sb.push_back(d0); acc++; end
      end
      if (cfi[1] && ack[1]) begin
         if (halted) drp++; else begin sb.push_back(d1); acc++; end
      end
      exp_pushed  = exp_pushed + acc;
      exp_dropped = (exp_dropped + drp > 65535) ? 65535 : exp_dropped + drp;
      if (fl) sb.delete();
      if (rst) begin
         sb.delete();
         exp_pushed  = 0;
         exp_dropped = 0;
      end
   endtask

   function automatic logic [W-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      checks        = 0;
      errors        = 0;
      exp_pushed    = 0;
      exp_dropped   = 0;
      mon_en        = 1'b0;
      rst_i         = 1'b1;
      flush_i       = 1'b0;
      log_i         = '0;
      log_cfi_i     = '0;
      log_ack_i     = '0;
      queue_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i  = 1'b0;
      mon_en = 1'b1;

      // Idle after reset
      for (int i = 0; i < 3; i++) apply_stimulus(2'b00, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0);

      // Two ports at once, draining with ready high
      apply_stimulus(2'b11, 2'b11, 64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) apply_stimulus(2'b00, 2'b00, '0, '0, 1'b1, 1'b0, 1'b0);

      // Fill to the halt level with ready low
      apply_stimulus(2'b01, 2'b01, 64'h1, '0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(2'b10, 2'b10, '0, 64'h2, 1'b0, 1'b0, 1'b0);
      apply_stimulus(2'b01, 2'b11, 64'h3, 64'h33, 1'b0, 1'b0, 1'b0);
      apply_stimulus(2'b00, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0);

      // Entries offered while halted are dropped
      apply_stimulus(2'b11, 2'b11, 64'hD0, 64'hD1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(2'b00, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0);

      // Pop one entry to reach occupancy 2, then flush with push and pop
      apply_stimulus(2'b00, 2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
      apply_stimulus(2'b01, 2'b01, 64'hF1, '0, 1'b1, 1'b1, 1'b0);
      apply_stimulus(2'b00, 2'b00, '0, '0, 1'b1, 1'b0, 1'b0);

      // Ordered stream across pointer wrap with ready toggling
      for (int i = 0; i < 14; i++) begin
         logic [W-1:0] v;
         v = 64'h100 + 64'(i);
         if (i % 2 == 0) apply_stimulus(2'b01, 2'b01, v, '0, 1'(i % 3 != 0), 1'b0, 1'b0);
         else            apply_stimulus(2'b10, 2'b10, '0, v, 1'(i % 3 != 0), 1'b0, 1'b0);
      end

      // Randomized traffic with occasional flush and reset
      for (int i = 0; i < 400; i++) begin
         apply_stimulus(N'($urandom), N'($urandom), rnd64(), rnd64(),
                        1'($urandom_range(0, 2) != 0),
                        1'($urandom_range(0, 31) == 0),
                        1'($urandom_range(0, 127) == 0));
      end

      // Drain
      for (int i = 0; i < 8; i++) apply_stimulus(2'b00, 2'b00, '0, '0, 1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
